// File: rtl/video_sync_gen.sv
// video_sync_gen -- programmable horizontal/vertical video timing generator.
//
// Two position counters (hcount, vcount) advance on ce. Sixteen timing
// registers exist twice: a shadow set written through wr_* at any time, and
// an active set that drives the counters and windows. The shadow set is
// copied into the active set only at frame end, so a frame always runs with
// one consistent timing set.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ce                       pixel-advance enable
//   wr_en/wr_addr/wr_data    shadow register write (0..6 horizontal,
//                            7..14 vertical, 15 INT_PIX)
//   hcount, vcount           current position
//   hsync..vpix              window levels
//   line_start, hsync_start,
//   frame_start, int_start   one-clock pulses
//   vga_hsync                doubled-rate hsync for a scandoubler
//   pending                  shadow set differs from active, awaiting frame end
//
// Optional feature: define VIDEO_SYNC_VGA_HSYNC_EN to build the vga_hsync
// doubling logic; otherwise vga_hsync is tied low.
module video_sync_gen #(
    parameter int HW         = 10,
    parameter int VW         = 9,
    parameter int H_TOTAL    = 448,
    parameter int H_BLNK_BEG = 320,
    parameter int H_BLNK_END = 416,
    parameter int H_SYNC_BEG = 336,
    parameter int H_SYNC_END = 368,
    parameter int H_PIX_BEG  = 32,
    parameter int H_PIX_END  = 288,
    parameter int V_TOTAL    = 320,
    parameter int V_BLNK_BEG = 240,
    parameter int V_BLNK_END = 272,
    parameter int V_SYNC_BEG = 248,
    parameter int V_SYNC_END = 252,
    parameter int V_PIX_BEG  = 24,
    parameter int V_PIX_END  = 216,
    parameter int INT_LINE   = 239,
    parameter int INT_PIX    = 318
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          wr_en,
    input  logic [3:0]    wr_addr,
    input  logic [HW-1:0] wr_data,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          hpix,
    output logic          vpix,
    output logic          line_start,
    output logic          hsync_start,
    output logic          frame_start,
    output logic          int_start,
    output logic          vga_hsync,
    output logic          pending
);

    // Index 0 is the LSB of the concatenation, i.e. the last element listed.
    localparam logic [15:0][HW-1:0] DEFAULTS = {
        HW'(INT_PIX),    HW'(INT_LINE),   HW'(V_PIX_END),  HW'(V_PIX_BEG),
        HW'(V_SYNC_END), HW'(V_SYNC_BEG), HW'(V_BLNK_END), HW'(V_BLNK_BEG),
        HW'(V_TOTAL),    HW'(H_PIX_END),  HW'(H_PIX_BEG),  HW'(H_SYNC_END),
        HW'(H_SYNC_BEG), HW'(H_BLNK_END), HW'(H_BLNK_BEG), HW'(H_TOTAL)
    };

    // BEG<END: plain window; BEG>END: window wraps through 0; BEG==END: empty.
    function automatic logic hwin(input logic [HW-1:0] c, b, e);
        if (b < e)      return (c >= b) && (c < e);
        else if (b > e) return (c >= b) || (c < e);
        else            return 1'b0;
    endfunction

    function automatic logic vwin(input logic [VW-1:0] c, b, e);
        if (b < e)      return (c >= b) && (c < e);
        else if (b > e) return (c >= b) || (c < e);
        else            return 1'b0;
    endfunction

    logic [15:0][HW-1:0] act_q, act_d, shd_q, shd_d;
    logic [HW-1:0]       hcount_q, hcount_d;
    logic [VW-1:0]       vcount_q, vcount_d;
    logic                pending_q, pending_d;
    logic [5:0]          lvl_q, lvl_d;   // {hsync,vsync,hblank,vblank,hpix,vpix}
    logic [3:0]          pls_q, pls_d;   // {line,hsync_start,frame,int}
    logic                h_last, v_last, apply;

    always_comb begin
        // A total of 0 makes TOTAL-1 all ones, i.e. the natural width wrap.
        h_last   = (hcount_q == act_q[0] - HW'(1));
        v_last   = (vcount_q == act_q[7][VW-1:0] - VW'(1));
        apply    = ce && h_last && v_last && pending_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (ce) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + VW'(1);
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end
        // The copy takes the shadow as it stood before this edge's write, so a
        // write on the apply edge waits for the next frame end.
        act_d = apply ? shd_q : act_q;
        shd_d = shd_q;
        if (wr_en) shd_d[wr_addr] = wr_data;
        pending_d = wr_en || (pending_q && !apply);

        // Outputs are computed from next-state values so they line up with
        // the counts registered on the same edge.
        lvl_d = {hwin(hcount_d, act_d[3], act_d[4]),
                 vwin(vcount_d, act_d[10][VW-1:0], act_d[11][VW-1:0]),
                 hwin(hcount_d, act_d[1], act_d[2]),
                 vwin(vcount_d, act_d[8][VW-1:0], act_d[9][VW-1:0]),
                 hwin(hcount_d, act_d[5], act_d[6]),
                 vwin(vcount_d, act_d[12][VW-1:0], act_d[13][VW-1:0])};
        pls_d = {ce && (hcount_d == '0),
                 ce && (hcount_d == act_d[3]),
                 ce && (hcount_d == '0) && (vcount_d == '0),
                 ce && (hcount_d == act_d[15]) && (vcount_d == act_d[14][VW-1:0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q     <= DEFAULTS;
            shd_q     <= DEFAULTS;
            hcount_q  <= '0;
            vcount_q  <= '0;
            pending_q <= 1'b0;
            lvl_q     <= '0;
            pls_q     <= '0;
        end else begin
            act_q     <= act_d;
            shd_q     <= shd_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            pending_q <= pending_d;
            lvl_q     <= lvl_d;
            pls_q     <= pls_d;
        end
    end

`ifdef VIDEO_SYNC_VGA_HSYNC_EN
    // Second pulse sits half a line after HSYNC_BEG; width is half the sync
    // width. A 0 total stands for 2^HW, hence the extra bit.
    logic [HW:0]   ht_full, p1_sum;
    logic [HW-1:0] p1, vw_w, vrem_q;
    logic          vhit, vga_q;

    always_comb begin
        ht_full = (act_d[0] == '0) ? {1'b1, {HW{1'b0}}} : {1'b0, act_d[0]};
        p1_sum  = {1'b0, act_d[3]} + (ht_full >> 1);
        if (p1_sum >= ht_full) p1_sum = p1_sum - ht_full;
        p1      = p1_sum[HW-1:0];
        vw_w    = (act_d[4] - act_d[3]) >> 1;
        vhit    = (hcount_d == act_d[3]) || (hcount_d == p1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_q  <= 1'b0;
            vrem_q <= '0;
        end else if (ce) begin
            if (vhit && vw_w != '0) begin
                vga_q  <= 1'b1;
                vrem_q <= vw_w - HW'(1);
            end else if (vrem_q != '0) begin
                vrem_q <= vrem_q - HW'(1);
            end else begin
                vga_q  <= 1'b0;
            end
        end
    end

    assign vga_hsync = vga_q;
`else
    assign vga_hsync = 1'b0;
`endif

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign pending     = pending_q;
    assign {hsync, vsync, hblank, vblank, hpix, vpix} = lvl_q;
    assign {line_start, hsync_start, frame_start, int_start} = pls_q;

endmodule

// File: doc/video_sync_gen.md
VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
REQ-001 SHALL have parameter HW, default 10: horizontal counter width.
REQ-002 SHALL have parameter VW, default 9: vertical counter width; HW >= VW is required.
REQ-003 SHALL have parameters H_TOTAL=448, H_BLNK_BEG=320, H_BLNK_END=416, H_SYNC_BEG=336, H_SYNC_END=368, H_PIX_BEG=32, H_PIX_END=288 as active-set reset values.
REQ-004 SHALL have parameters V_TOTAL=320, V_BLNK_BEG=240, V_BLNK_END=272, V_SYNC_BEG=248, V_SYNC_END=252, V_PIX_BEG=24, V_PIX_END=216, INT_LINE=239, INT_PIX=318 as active-set reset values.
REQ-005 clk  in  1  system clock (28 MHz); sole clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ce  in  1  pixel-advance enable (driven from cend).
REQ-008 wr_en  in  1  timing register write strobe.
REQ-009 wr_addr  in  4  timing register index, map in REQ-016.
REQ-010 wr_data  in  HW  timing register value; upper HW-VW bits ignored for vertical registers.
REQ-011 hcount  out  HW  / vcount  out  VW  current position.
REQ-012 hsync, vsync, hblank, vblank, hpix, vpix  out  1 each  window levels.
REQ-013 line_start, hsync_start, frame_start, int_start  out  1 each  one-clk pulses.
REQ-014 vga_hsync  out  1  doubled-rate hsync for the scandoubler.
REQ-015 pending  out  1  shadow timing set awaiting application.

Function
REQ-016 Register map: 0 HTOTAL, 1 HBLNK_BEG, 2 HBLNK_END, 3 HSYNC_BEG, 4 HSYNC_END, 5 HPIX_BEG, 6 HPIX_END, 7 VTOTAL, 8 VBLNK_BEG, 9 VBLNK_END, 10 VSYNC_BEG, 11 VSYNC_END, 12 VPIX_BEG, 13 VPIX_END, 14 INT_LINE, 15 INT_PIX.
REQ-017 wr_en SHALL write shadow register wr_addr and set pending on the next clk edge, regardless of ce.
REQ-018 On a ce cycle where hcount==HTOTAL-1: hcount SHALL wrap to 0 and vcount SHALL increment, wrapping to 0 when vcount==VTOTAL-1; otherwise hcount increments on ce only.
REQ-019 At the vcount wrap (frame end), if pending, the whole shadow set SHALL copy into the active set and pending SHALL clear in the same edge.
REQ-020 A wr_en coinciding with the apply edge SHALL update the shadow, leave pending set, and take effect at the following frame end.
REQ-021 Window rule for each level output: if BEG<END, high when BEG<=count<END; if BEG>END, high when count>=BEG or count<END; if BEG==END, always low.
REQ-022 All outputs SHALL be registered and consistent with the hcount/vcount values presented in the same cycle.
REQ-023 line_start SHALL pulse one clk when hcount becomes 0; frame_start when hcount and vcount both become 0; hsync_start when hcount becomes HSYNC_BEG.
REQ-024 int_start SHALL pulse one clk when (vcount,hcount) becomes (INT_LINE,INT_PIX); it never fires if the position is outside the totals.
REQ-025 If HTOTAL or VTOTAL is written below the current count, the counter SHALL keep running to its width-wrap (all ones -> 0) only after application; apply occurs only at frame end, so active totals never change mid-frame.
REQ-026 HTOTAL or VTOTAL of 0 SHALL be treated as 2^HW (resp. 2^VW).

Reset
REQ-027 rst SHALL set hcount=0, vcount=0, pending=0, all pulses and levels 0, vga_hsync 0, and load active and shadow sets from parameters; rst overrides wr_en and ce in the same cycle.
REQ-028 First ce after rst release SHALL yield hcount=1, vcount=0.

Configuration
REQ-029 Macro VIDEO_SYNC_VGA_HSYNC_EN defined: vga_hsync SHALL be high for (HSYNC_END-HSYNC_BEG)/2 ce cycles starting at hcount==HSYNC_BEG and again at hcount==HSYNC_BEG+HTOTAL/2 (mod HTOTAL), widths floored.
REQ-030 Macro absent: vga_hsync SHALL be constant 0 and no doubling logic SHALL be synthesised.

Verification
REQ-031 Reset, ce every 4th clk, defaults -> line_start every 1792 clk; frame_start every 573440 clk; hsync high hcount 336..367.
REQ-032 Defaults -> int_start exactly once per frame at vcount=239, hcount=318; vsync high lines 248..251.
REQ-033 Write HTOTAL=400 mid-frame -> pending=1, line period stays 448 until frame end, then 400; pending=0.
REQ-034 Write HSYNC_BEG=440, HSYNC_END=8, apply -> hsync high hcount 440..447 and 0..7; write BEG=END=100 -> hsync never high.
REQ-035 Assert rst mid-line at hcount=200 with pending=1 -> next cycle hcount=0, pending=0, defaults active.
REQ-036 With VIDEO_SYNC_VGA_HSYNC_EN, defaults -> vga_hsync pulses of 16 ce at hcount 336 and 112; without macro -> vga_hsync stays 0.
